// File: rtl/pacman_move_ctrl_pkg.sv
// rtl/pacman_move_ctrl_pkg.sv - shared types, defaults and pixel mapping for the player movement controller
package pacman_pkg;

  localparam int CELL_W     = 5;
  localparam int GRID_N_DEF = 18;
  localparam int STEP_DEF   = 20;
  localparam int ORIGIN_DEF = 50;

  typedef enum logic [1:0] {CLEAR, IDLE, MOVE, CHECK} state_t;

  typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  function automatic logic [9:0] cell_to_pix(input logic [CELL_W-1:0] c, input int step, input int origin);
    return 10'(origin + step * int'(c));
  endfunction

endpackage

// File: rtl/pacman_move_ctrl_if.sv
// rtl/pacman_move_ctrl_if.sv - button inputs and position/score outputs of the movement controller
interface pacman_move_ctrl_if;
  import pacman_pkg::*;

  logic              btn_up;
  logic              btn_down;
  logic              btn_left;
  logic              btn_right;
  logic              btn_restart;
  logic [9:0]        xpos;
  logic [8:0]        ypos;
  logic [CELL_W-1:0] cell_x;
  logic [CELL_W-1:0] cell_y;
  logic [15:0]       score_bcd;
  logic              pellet_eaten;
  logic              busy;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_restart,
    input  xpos, ypos, cell_x, cell_y, score_bcd, pellet_eaten, busy
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_restart,
    output xpos, ypos, cell_x, cell_y, score_bcd, pellet_eaten, busy
  );

endinterface

// File: rtl/pacman_move_ctrl_bcd_counter4.sv
// rtl/pacman_move_ctrl_bcd_counter4.sv - 4-digit BCD incrementer, saturating at 9999
module bcd_counter4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] value_o
);

  logic [15:0] value_q, value_d;
  logic        carry;

  always_comb begin
    value_d = value_q;
    carry   = 1'b0;
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i && (value_q != 16'h9999)) begin
      // Ripple the +1 upward; a digit passing 9 wraps to 0 and carries on.
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (value_q[4*i +: 4] == 4'd9) begin
            value_d[4*i +: 4] = 4'd0;
          end else begin
            value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/pacman_move_ctrl.sv
// rtl/pacman_move_ctrl.sv - player movement, visited bitmap and pellet score sequencer
// Optional WRAP_EN: moves past a grid edge wrap to the opposite edge instead of being blocked.
module pacman_move_ctrl
  import pacman_pkg::*;
#(
  parameter int TICK_DIV = 2500000,
  parameter int GRID_N   = GRID_N_DEF,
  parameter int STEP     = STEP_DEF,
  parameter int ORIGIN   = ORIGIN_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  pacman_move_ctrl_if.slave  bus
);

  localparam int                CNT_W = $clog2(TICK_DIV);
  localparam logic [CELL_W-1:0] LAST  = CELL_W'(GRID_N - 1);
  localparam logic [CELL_W-1:0] ONE   = CELL_W'(1);
`ifdef WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [4:0] sync1_q, sync2_q;
  logic       up_s, down_s, left_s, right_s, restart_s;

  state_t            state_q, state_d;
  dir_t              dir_q, dir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CELL_W-1:0] row_q, row_d;
  logic [CELL_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [CELL_W-1:0] nx, ny;
  logic [9:0]        xpos_q, xpos_d;
  logic [8:0]        ypos_q, ypos_d;
  logic              pel_q, pel_d;
  logic              tick, visited;
  logic              clear_row, mark_origin, mark_cell;
  logic              score_clr, score_inc;
  logic [15:0]       score;
  logic [GRID_N-1:0] bitmap_q [GRID_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus.btn_restart, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
      sync2_q <= sync1_q;
    end
  end

  assign {restart_s, right_s, left_s, down_s, up_s} = sync2_q;

  assign tick    = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign visited = bitmap_q[cy_q][cx_q];

  always_comb begin
    nx = cx_q;
    ny = cy_q;
    case (dir_q)
      DIR_UP:    if (cy_q != '0)   ny = cy_q - ONE; else if (WRAP) ny = LAST;
      DIR_DOWN:  if (cy_q != LAST) ny = cy_q + ONE; else if (WRAP) ny = '0;
      DIR_LEFT:  if (cx_q != '0)   nx = cx_q - ONE; else if (WRAP) nx = LAST;
      DIR_RIGHT: if (cx_q != LAST) nx = cx_q + ONE; else if (WRAP) nx = '0;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    row_d       = row_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    pel_d       = 1'b0;
    clear_row   = 1'b0;
    mark_origin = 1'b0;
    mark_cell   = 1'b0;
    score_clr   = 1'b0;
    score_inc   = 1'b0;
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    case (state_q)
      CLEAR: begin
        clear_row = 1'b1;
        if (row_q == LAST) begin
          row_d       = '0;
          mark_origin = 1'b1;
          state_d     = IDLE;
        end else begin
          row_d = row_q + ONE;
        end
      end
      IDLE: begin
        if (restart_s) begin
          state_d   = CLEAR;
          cnt_d     = '0;
          score_clr = 1'b1;
          cx_d      = '0;
          cy_d      = '0;
          xpos_d    = 10'(ORIGIN);
          ypos_d    = 9'(ORIGIN);
        end else if (tick) begin
          state_d = MOVE;
          dir_d   = up_s    ? DIR_UP    :
                    down_s  ? DIR_DOWN  :
                    left_s  ? DIR_LEFT  :
                    right_s ? DIR_RIGHT : DIR_NONE;
        end
      end
      MOVE: begin
        cx_d    = nx;
        cy_d    = ny;
        xpos_d  = cell_to_pix(nx, STEP, ORIGIN);
        ypos_d  = 9'(cell_to_pix(ny, STEP, ORIGIN));
        state_d = CHECK;
      end
      CHECK: begin
        // Stationary or blocked steps land on a visited cell, so they never score.
        if (!visited) begin
          mark_cell = 1'b1;
          pel_d     = 1'b1;
          score_inc = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      dir_q   <= DIR_NONE;
      cnt_q   <= '0;
      row_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      xpos_q  <= 10'(ORIGIN);
      ypos_q  <= 9'(ORIGIN);
      pel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      pel_q   <= pel_d;
    end
  end

  // No reset on the bitmap: CLEAR always runs after reset and wipes it row by row.
  always_ff @(posedge clk) begin
    if (clear_row)   bitmap_q[row_q]      <= '0;
    if (mark_origin) bitmap_q[0][0]       <= 1'b1;
    if (mark_cell)   bitmap_q[cy_q][cx_q] <= 1'b1;
  end

  bcd_counter4 u_score (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (score_clr),
    .inc_i   (score_inc),
    .value_o (score)
  );

  assign bus.xpos         = xpos_q;
  assign bus.ypos         = ypos_q;
  assign bus.cell_x       = cx_q;
  assign bus.cell_y       = cy_q;
  assign bus.score_bcd    = score;
  assign bus.pellet_eaten = pel_q;
  assign bus.busy         = (state_q != IDLE);

endmodule
